// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants for the EX-stage RV32M multiply/divide unit: funct3 codes,
// FSM encoding and default widths.
package muldiv_pkg;

  localparam int         XLEN_DEFAULT = 32;
  localparam logic [6:0] M_FUNCT7     = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: operands and control in,
// stall/busy/done/result out.
interface ex_muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            flush;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output flush, start, funct3, a, b,
                  input  stall, busy, done, result);
  modport slave  (input  flush, start, funct3, a, b,
                  output stall, busy, done, result);
endinterface

// File: rtl/ex_muldiv_unit_iter_core.sv
// One-bit-per-cycle datapath shared by shift-add multiply and restoring divide.
// {hi,lo} is the product (multiply) or {remainder,quotient} (divide).
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic [XLEN-1:0] lo_i,
  output logic            last_o,
  output logic [XLEN-1:0] hi_next_o,
  output logic [XLEN-1:0] lo_next_o
);
  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] opnd_q, hi_q, lo_q, hi_d, lo_d, addend;
  logic [CW-1:0]   cnt_q;
  logic            div_q;
  logic [XLEN:0]   sum, rem_sh, diff;

  // NOTE: every always_comb output gets a default on every path so no latch is inferred.
  always_comb begin
    addend = lo_q[0] ? opnd_q : '0;
    sum    = {1'b0, hi_q} + {1'b0, addend};
    rem_sh = {hi_q, lo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    hi_d   = sum[XLEN:1];
    lo_d   = {sum[0], lo_q[XLEN-1:1]};
    if (div_q) begin
      // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
      if (!diff[XLEN]) begin
        hi_d = diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign last_o    = (cnt_q == CW'(XLEN - 1));
  assign hi_next_o = hi_d;
  assign lo_next_o = lo_d;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      opnd_q <= opnd_i;
      hi_q   <= '0;
      lo_q   <= lo_i;
      cnt_q  <= '0;
      div_q  <= is_div_i;
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage: FSM, sign handling and special cases.
// Define MULDIV_FAST_MUL_EN to complete multiplies in one cycle with a combinational multiplier.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  ex_muldiv_unit_if.slave  bus
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [2:0]      f3_q;
  logic            neg_q, neg_rem_q;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept, is_div, sgn_a, sgn_b, neg_a, neg_b, direct, last;
  logic [XLEN-1:0] abs_a, abs_b, direct_res, iter_res, hi_next, lo_next;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] p,
                                              input logic neg, input logic [2:0] f3);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (f3 == F3_MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_sel(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                              input logic nq, input logic nr, input logic rem);
    if (rem) return nr ? -r : r;
    return nq ? -q : q;
  endfunction

  // Operand conditioning: the core works on magnitudes, signs are reapplied at the end.
  always_comb begin
    is_div = bus.funct3[2];
    sgn_a  = (bus.funct3 == F3_MULH) | (bus.funct3 == F3_MULHSU) |
             (bus.funct3 == F3_DIV)  | (bus.funct3 == F3_REM);
    sgn_b  = (bus.funct3 == F3_MULH) | (bus.funct3 == F3_DIV) | (bus.funct3 == F3_REM);
    neg_a  = sgn_a & bus.a[XLEN-1];
    neg_b  = sgn_b & bus.b[XLEN-1];
    abs_a  = neg_a ? -bus.a : bus.a;
    abs_b  = neg_b ? -bus.b : bus.b;
    direct = is_div & ((bus.b == '0) |
                       (~bus.funct3[0] & (bus.a == MIN_NEG) & (bus.b == '1)));
    if (bus.b == '0) direct_res = bus.funct3[1] ? bus.a : '1;
    else             direct_res = bus.funct3[1] ? '0 : MIN_NEG;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
    if (!is_div) begin
      direct     = 1'b1;
      direct_res = mul_sel(fast_prod, neg_a ^ neg_b, bus.funct3);
    end
`endif
  end

  assign accept   = (state_q == S_IDLE) & bus.start & ~bus.flush;
  assign iter_res = f3_q[2] ? div_sel(lo_next, hi_next, neg_q, neg_rem_q, f3_q[1])
                            : mul_sel({hi_next, lo_next}, neg_q, f3_q);

  // The result register is written on the edge entering DONE so it is valid alongside done.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (direct) begin
          state_d  = S_DONE;
          result_d = direct_res;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: if (bus.flush) begin
        state_d = S_IDLE;
      end else if (last) begin
        state_d  = S_DONE;
        result_d = iter_res;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        f3_q      <= bus.funct3;
        neg_q     <= neg_a ^ neg_b;
        neg_rem_q <= neg_a;
      end
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .step_i   ((state_q == S_BUSY) & ~bus.flush),
    .is_div_i (is_div),
    .opnd_i   (is_div ? abs_b : abs_a),
    .lo_i     (is_div ? abs_a : abs_b),
    .last_o   (last),
    .hi_next_o(hi_next),
    .lo_next_o(lo_next)
  );

  assign bus.busy   = (state_q == S_BUSY);
  assign bus.done   = (state_q == S_DONE);
  assign bus.stall  = ~rst & (accept | (state_q == S_BUSY));
  assign bus.result = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: results, stall length, flush, reset
// and back-to-back issue.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = XLEN + 1;
`endif
  localparam int DIV_STALL = XLEN + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(XLEN)) bus ();
  ex_muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge, hold start until done, scramble operands after acceptance.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_res, input int exp_stall);
    int stalls = 0;
    int cyc    = 0;
    bit seen   = 1'b0;
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = av;
    bus.b      = bv;
    while (!seen && cyc < 200) begin
      #1;
      if (bus.stall) stalls++;
      if (bus.done) begin
        seen = 1'b1;
        check({tag, " result"}, bus.result, exp_res);
        bus.start = 1'b0;
      end else if (cyc == 1) begin
        bus.a = ~av;
        bus.b = ~bv;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stall));
    #1;
    check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dones;
    int span;
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.flush  = 1'b0;
    bus.funct3 = F3_MUL;
    bus.a      = 32'd3;
    bus.b      = 32'd5;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset busy",   32'(bus.busy),  32'd0);
    check("reset done",   32'(bus.done),  32'd0);
    check("reset stall",  32'(bus.stall), 32'd0);
    check("reset result", bus.result,     32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    run_op("MUL 7*-3",        F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_STALL);
    run_op("MUL small",       F3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, MUL_STALL);
    run_op("MULH min*min",    F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_STALL);
    run_op("MULH -1*2",       F3_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_STALL);
    run_op("MULHU max*max",   F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_STALL);
    run_op("MULHU 2^31*4",    F3_MULHU,  32'h80000000, 32'h00000004, 32'h00000002, MUL_STALL);
    run_op("MULHSU -1*max",   F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_STALL);
    run_op("DIV -7/2",        F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_STALL);
    run_op("REM -7%2",        F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_STALL);
    run_op("DIV 7/-2",        F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_STALL);
    run_op("REM 7%-2",        F3_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_STALL);
    run_op("DIVU 100/7",      F3_DIVU,   32'd100,      32'd7,        32'd14,       DIV_STALL);
    run_op("REMU 100%7",      F3_REMU,   32'd100,      32'd7,        32'd2,        DIV_STALL);
    run_op("DIVU 2^31/max",   F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, DIV_STALL);
    run_op("REMU 2^31%max",   F3_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_STALL);
    run_op("DIV 5/0",         F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("DIVU 5/0",        F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("REMU 5%0",        F3_REMU,   32'd5,        32'd0,        32'd5,        1);
    run_op("REM -7%0",        F3_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
    run_op("DIV overflow",    F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM overflow",    F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Flush a long divide in its tenth BUSY cycle; the previous result must survive.
    bus.start  = 1'b1;
    bus.funct3 = F3_DIVU;
    bus.a      = 32'd1000;
    bus.b      = 32'd3;
    @(negedge clk);
    for (int i = 0; i < 9; i++) @(negedge clk);
    #1;
    check("flush busy before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush busy after", 32'(bus.busy),  32'd0);
    check("flush stall",      32'(bus.stall), 32'd0);
    check("flush result",     bus.result,     32'h00000000);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("flush no done", 32'(dones), 32'd0);
    @(negedge clk);

    run_op("DIVU 100/7 again", F3_DIVU, 32'd100, 32'd7, 32'd14, DIV_STALL);

    // Asynchronous reset in the middle of a divide, start still asserted.
    bus.start  = 1'b1;
    bus.funct3 = F3_DIV;
    bus.a      = 32'd77;
    bus.b      = 32'd5;
    for (int i = 0; i < 6; i++) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst mid busy",   32'(bus.busy),  32'd0);
    check("rst mid stall",  32'(bus.stall), 32'd0);
    check("rst mid result", bus.result,     32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    // Back-to-back MULs with start held through the first DONE cycle.
    bus.start  = 1'b1;
    bus.funct3 = F3_MUL;
    bus.a      = 32'd7;
    bus.b      = 32'hFFFFFFFD;
    dones = 0;
    span  = 0;
    for (int cyc = 0; cyc < 200 && dones < 2; cyc++) begin
      #1;
      if (dones == 1) span++;
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          span = 1;
          check("b2b first result", bus.result, 32'hFFFFFFEB);
          bus.a = 32'h12345678;
          bus.b = 32'h00000010;
        end else begin
          check("b2b second result", bus.result, 32'h23456780);
          bus.start = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b span", 32'(span), 32'(MUL_STALL + 2));
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("b2b done count", 32'(dones), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes operands and funct3 from the ID/EX pipeline register outputs (A_EX, B_EX, IR_EX[14:12]).
- Asserts stall so the hazard logic holds PC, IF/ID and ID/EX (EN low) while it computes.
- Delivers a 32-bit result to the EX/MEM write-back mux with a one-cycle done pulse.

Parameters:
XLEN, 32, operand/result width; also the iteration count of the shift-add / restoring-divide loop.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
flush  input  1  kill the instruction in EX; aborts any operation in flight
start  input  1  EX instruction is an M-extension op (opcode 0110011, funct7 0000001); held high while stalled
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  XLEN  rs1 operand (forwarded)
b  input  XLEN  rs2 operand (forwarded)
stall  output  1  hold upstream stages this cycle
busy  output  1  FSM in BUSY
done  output  1  one-cycle pulse; result valid
result  output  XLEN  last completed result, held until the next completion

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, internal counter/accumulators cleared; stall forced 0 while rst is high. Reset mid-operation discards the operation.
- States:
  - IDLE: start=1 and flush=0 -> latch a, b, funct3 and operand signs; take absolute values for signed ops; counter=0.
    - Special case (divide/remainder with b==0, or signed overflow a=0x80000000, b=0xFFFFFFFF) -> go straight to DONE.
    - Otherwise -> BUSY.
  - BUSY: one bit per cycle; counter increments; at counter==XLEN-1 -> DONE.
    - Multiply: shift-add into a 2*XLEN product.
    - Divide: restoring division producing quotient and remainder.
  - DONE: done=1; result register updated this cycle with the sign-corrected value; unconditional -> IDLE.
- stall = (IDLE & start & ~flush) | BUSY. Deasserted in DONE, so ID/EX advances on the edge ending DONE.
- Latency:
  - Normal op: 1 accept cycle + XLEN BUSY cycles, then DONE; stall high for XLEN+1 cycles.
  - Special case: stall high 1 cycle, DONE on the next.
- Back-to-back M-ops: the new instruction arrives in EX the cycle after DONE (state IDLE) and is accepted then. start seen in DONE is ignored, so the same instruction never executes twice.
- start while BUSY: ignored; operands are latched only in IDLE.
- flush: in IDLE or BUSY -> IDLE next cycle, no done, result unchanged. In DONE, done still pulses (the instruction already retired from EX).
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH / MULHSU / MULHU: high XLEN bits of the signed*signed / signed*unsigned / unsigned*unsigned product.
  - Sign correction: product negated if operand signs differ (per op signedness). Quotient negated if signs differ. Remainder takes the sign of a.
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
  - Overflow: DIV -> 0x80000000; REM -> 0.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: multiplies use a combinational XLEN*XLEN multiplier. IDLE -> DONE directly, so stall is high 1 cycle; divides are unchanged.
- Undefined: all ops are iterative as above; no multiplier inferred.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (F3_MUL … F3_REMU).
  - FSM state encoding (S_IDLE, S_BUSY, S_DONE, 2 bits).
  - Constants XLEN_DEFAULT, M_FUNCT7=7'b0000001.
- Sub-module muldiv_iter_core:
  - Holds the shift registers, accumulator, counter and one-step shift-add / restore-subtract datapath.
  - Controlled by load/step/op-is-div inputs.
- FSM, sign handling and special cases stay in ex_muldiv_unit.

Test Plan:
1. MUL a=7, b=-3 -> stall high 33 cycles, done pulse, result=0xFFFFFFEB (-21).
2. MULH a=0x80000000, b=0x80000000 -> result=0x40000000. MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE.
3. DIV a=-7, b=2 -> result=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU a=100, b=7 -> 14.
4. DIV a=5, b=0 -> stall 1 cycle, result=0xFFFFFFFF. REMU a=5, b=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
5. flush asserted at BUSY cycle 10 -> IDLE next cycle, no done, result keeps prior value. rst pulsed mid-BUSY -> busy=0, result=0.
6. Two back-to-back MULs (start held across the DONE cycle) -> exactly two done pulses, 35 total cycles (33 + 2) for the second result, no duplicate execution. With MULDIV_FAST_MUL_EN: each MUL stalls 1 cycle.
